// File: rtl/florete_pkg.sv
// -----------------------------------------------------------------------------
// florete_pkg
// Shared constants for the Toom-Cook multiplier back end.
//   N_COEFF / N_WORDS : polynomial length and number of 64-bit words holding it
//   N_LANES / LANE_STRIDE : interleaved limb layout, word j lane m holds
//                           coefficient j + LANE_STRIDE*m, lane 0 at [15:0]
//   HI_OFFSET         : word offset of coefficients 256..511 from the product base
//   PROD_BASE_DEF     : default word address of the product in the shared BRAM
//   state_e           : poly_reduce_256 FSM states
// -----------------------------------------------------------------------------
package florete_pkg;
   localparam int N_COEFF       = 256;
   localparam int N_WORDS       = 64;
   localparam int N_LANES       = 4;
   localparam int LANE_STRIDE   = 64;
   localparam int HI_OFFSET     = N_WORDS;
   localparam int PROD_BASE_DEF = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_HI,
      S_LO,
      S_FLUSH
   } state_e;

   // Coefficient index held by word j, lane m.
   function automatic int coeff_index(input int j, input int m);
      return j + LANE_STRIDE * m;
   endfunction
endpackage

// File: rtl/poly_reduce_256_if.sv
// -----------------------------------------------------------------------------
// poly_reduce_256_if
// Bus bundle between poly_reduce_256 and its surroundings.
//   start      : one-cycle request
//   prod_addr  : product BRAM read address (1-cycle latency)
//   prod_data  : product BRAM read data
//   acc_addr   : accumulator RAM address (single port, 1-cycle read latency)
//   acc_rdata  : accumulator read data
//   acc_wdata  : accumulator write data
//   acc_we     : accumulator write enable
//   busy, done : status
// Modports: slave = the reducer, master = the side driving start and the RAMs.
// -----------------------------------------------------------------------------
interface poly_reduce_256_if;
   logic        start;
   logic [7:0]  prod_addr;
   logic [63:0] prod_data;
   logic [5:0]  acc_addr;
   logic [63:0] acc_rdata;
   logic [63:0] acc_wdata;
   logic        acc_we;
   logic        busy;
   logic        done;

   modport slave (
      input  start, prod_data, acc_rdata,
      output prod_addr, acc_addr, acc_wdata, acc_we, busy, done
   );

   modport master (
      output start, prod_data, acc_rdata,
      input  prod_addr, acc_addr, acc_wdata, acc_we, busy, done
   );
endinterface

// File: rtl/poly_reduce_256_lane.sv
// -----------------------------------------------------------------------------
// poly_reduce_lane
// One 16-bit lane of the negacyclic fold: out = (lo - hi + acc) mod 2^W,
// masked to LOG_Q bits. Purely combinational.
//   lo_i  : coefficient i
//   hi_i  : coefficient i+256 (subtracted because x^256 = -1)
//   acc_i : previous accumulator lane (zero when accumulation is off)
//   out_o : masked result
// -----------------------------------------------------------------------------
module poly_reduce_lane #(
   parameter int COEFF_WIDTH = 16,
   parameter int LOG_Q       = 13
) (
   input  logic [COEFF_WIDTH-1:0] lo_i,
   input  logic [COEFF_WIDTH-1:0] hi_i,
   input  logic [COEFF_WIDTH-1:0] acc_i,
   output logic [COEFF_WIDTH-1:0] out_o
);
   // Built in 64 bits so LOG_Q == COEFF_WIDTH does not need a zero-width field.
   localparam logic [COEFF_WIDTH-1:0] MASK = COEFF_WIDTH'((64'd1 << LOG_Q) - 64'd1);

   logic [COEFF_WIDTH-1:0] diff;
   logic [COEFF_WIDTH-1:0] sum;

   assign diff  = lo_i - hi_i;   // wraps mod 2^W
   assign sum   = diff + acc_i;
   assign out_o = sum & MASK;
endmodule

// File: rtl/poly_reduce_256.sv
// -----------------------------------------------------------------------------
// poly_reduce_256
// Folds the 512-coefficient product in the shared BRAM modulo x^256+1 and
// writes the 64-word result (LOG_Q-bit lanes) into the accumulator RAM.
// Word j of the result is c[j+64m] - c[j+64m+256] in lane m.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : poly_reduce_256_if.slave (start, product read, accumulator r/w,
//            busy, done)
// Build option: POLY_REDUCE_ACC_EN adds the previous accumulator contents
// into each result (read-modify-write); undefined, the result overwrites.
// Each word takes a HI cycle (low word arrives, accumulator read issued) and
// a LO cycle (high word arrives, write); read and write never share a cycle.
// -----------------------------------------------------------------------------
module poly_reduce_256
   import florete_pkg::*;
#(
   parameter int COEFF_WIDTH = 16,
   parameter int LOG_Q       = 13,
   parameter int PROD_BASE   = PROD_BASE_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   poly_reduce_256_if.slave  bus
);
   localparam logic [7:0] BASE_A  = 8'(PROD_BASE);
   localparam logic [7:0] HIOFF_A = 8'(HI_OFFSET);
   localparam logic [5:0] J_LAST  = 6'(N_WORDS - 1);

   state_e               state_q;
   logic [5:0]           j_q;
   logic [63:0]          lo_q;
   logic                 done_q;
   logic                 we;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         j_q     <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state_q == S_FLUSH);
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q <= S_PRIME;
                  j_q     <= '0;
               end
            end
            S_PRIME: state_q <= S_HI;
            S_HI: begin
               lo_q    <= bus.prod_data;
               state_q <= (j_q == J_LAST) ? S_FLUSH : S_LO;
            end
            S_LO: begin
               j_q     <= j_q + 6'd1;
               state_q <= S_HI;
            end
            S_FLUSH: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------- control decode
   // The product read for the next phase is always issued one cycle early:
   // HI requests the high word j, LO requests the low word j+1.
   always_comb begin
      bus.prod_addr = '0;
      bus.acc_addr  = '0;
      we            = 1'b0;
      unique case (state_q)
         S_PRIME: bus.prod_addr = BASE_A;
         S_HI: begin
            bus.prod_addr = BASE_A + HIOFF_A + {2'b00, j_q};
            bus.acc_addr  = j_q;
         end
         S_LO: begin
            bus.prod_addr = BASE_A + {2'b00, j_q} + 8'd1;
            bus.acc_addr  = j_q;
            we            = 1'b1;
         end
         S_FLUSH: begin
            bus.acc_addr  = j_q;
            we            = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.acc_we = we;
   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = done_q;

   // -------------------------------------------------------- datapath
   logic [N_LANES-1:0][COEFF_WIDTH-1:0] lo_l, hi_l, acc_l, out_l;

   assign lo_l = lo_q;
   assign hi_l = bus.prod_data;

`ifdef POLY_REDUCE_ACC_EN
   assign acc_l = bus.acc_rdata;
`else
   assign acc_l = '0;
   logic unused_acc;
   assign unused_acc = ^bus.acc_rdata;
`endif

   for (genvar m = 0; m < N_LANES; m++) begin : g_lane
      poly_reduce_lane #(
         .COEFF_WIDTH (COEFF_WIDTH),
         .LOG_Q       (LOG_Q)
      ) u_lane (
         .lo_i  (lo_l[m]),
         .hi_i  (hi_l[m]),
         .acc_i (acc_l[m]),
         .out_o (out_l[m])
      );
   end

   // Held at zero outside write cycles so the bus is quiet when idle.
   assign bus.acc_wdata = we ? out_l : '0;
endmodule

// File: doc/poly_reduce_256.md
# poly_reduce_256

Downstream stage of the 4-way Toom-Cook 256x256 multiplier. Reads the 512-coefficient product that the multiplier leaves in the upper half of the shared 64-bit-wide BRAM, and folds it modulo x^256+1 (c[i] - c[i+256]). The result is masked to LOG_Q bits and written as 64 words into a separate accumulator RAM, optionally accumulating onto its previous contents. Data stays in the multiplier's interleaved limb layout throughout: word j, lane m holds coefficient j+64m, lane 0 at [15:0]. The output can therefore feed the multiplier's data_in directly.

## Interface
- COEFF_WIDTH, 16, lane width in bits.
- LOG_Q, 13, output modulus bits; result lanes are masked to LOG_Q LSBs and upper bits are zero.
- PROD_BASE, 128, 64-bit word address of product coefficients 0..255; coefficients 256..511 sit at PROD_BASE+64.
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- prod_addr  out  8  product BRAM read address, 1-cycle read latency.
- prod_data  in  64  product BRAM read data.
- acc_addr  out  6  accumulator RAM address, single port, 1-cycle read latency.
- acc_rdata  in  64  accumulator read data; used only with POLY_REDUCE_ACC_EN.
- acc_wdata  out  64  accumulator write data.
- acc_we  out  1  accumulator write enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last write.

## Operation
- FSM states: IDLE, PRIME, HI, LO, FLUSH. The word counter j is 6 bits.
- IDLE:
  - start=1 → PRIME, with j=0.
  - start while busy is ignored; it is not queued.
- PRIME: prod_addr = PROD_BASE + 0 → HI.
- HI:
  - prod_addr = PROD_BASE + 64 + j.
  - Capture prod_data into lo_reg (low half, word j).
  - acc_addr = j, as a read.
  - If j=63 → FLUSH, else → LO.
- LO:
  - prod_addr = PROD_BASE + j + 1.
  - prod_data is the high word j.
  - acc_addr = j, acc_we=1, acc_wdata = result(j).
  - j ← j+1 → HI.
- FLUSH: same write as LO for j=63, with no new read → IDLE. done pulses in the following cycle.
- Lane arithmetic (m = 0..3), mod 2^16:
  - d_m = lo_m − hi_m.
  - s_m = d_m + acc_m with ACC_EN, otherwise d_m.
  - out_m = s_m & (2^LOG_Q − 1).
- Read and write to the accumulator never fall in the same cycle, so a single-port RAM suffices.
- Reset mid-operation:
  - FSM returns to IDLE.
  - No further acc_we.
  - done stays 0; a partially written accumulator is not restored.

## Timing
- Reset values: state IDLE, j=0, lo_reg=0, prod_addr=0, acc_addr=0, acc_wdata=0, acc_we=0, busy=0, done=0.
- Control outputs (prod_addr, acc_addr, acc_we, busy) decode from the registered state and j only.
- acc_wdata is combinational from lo_reg, prod_data and acc_rdata.
- Cycle 0 is the edge that samples start:
  - PRIME in cycle 1.
  - First write (j=0) in cycle 3.
  - Writes repeat every 2 cycles; the write for j=63 (FLUSH) is in cycle 129.
  - done is high in cycle 130, with busy=0 in that cycle.
  - A new start is accepted in cycle 130.
- Throughput: one 64-bit result word per 2 cycles, 130 cycles per polynomial.

## Configuration
- POLY_REDUCE_ACC_EN defined:
  - HI drives the accumulator read.
  - out_m includes acc_m, giving a matrix-vector inner-product accumulate.
- POLY_REDUCE_ACC_EN undefined:
  - acc_rdata is unused and tied off by the integrator.
  - The output is an overwrite with (lo − hi) masked; addressing and timing are unchanged.

## Structure
- Shared package florete_pkg holds:
  - N_COEFF=256, N_WORDS=64.
  - The lane-layout helper constants (lane m ↔ coefficient offset 64m).
  - The FSM state enum.
  - PROD_BASE default.
- One sub-module, poly_reduce_lane: a combinational per-lane subtract, optional add, and mask. It is instanced 4 times.

## Test plan
- Reset: hold resetn=0, assert start → all outputs 0, no acc_we; release → IDLE, busy=0.
- Plain fold, no ACC_EN: product words all-zero except coefficient 0 = 5 and coefficient 256 = 7:
  - word 0 lane 0 = (5−7)&0x1FFF = 0x1FFE.
  - All other lanes 0.
  - 64 writes, done exactly at cycle 130.
- ACC_EN: accumulator preloaded with 0x1FFF in every lane, coefficient 64 = 3, coefficient 320 = 1 → word 0 lane 1 = (2+0x1FFF)&0x1FFF = 0x0001; other lanes 0x1FFF.
- Wrap-around: lo lane = 0x0000, hi lane = 0xFFFF, LOG_Q=16 → 0x0001. Random 512-coefficient vectors are checked against a software negacyclic model.
- Handshake: start pulsed at cycles 5 and 60 of a run → second ignored, exactly 64 writes, single done. A start in the done cycle begins a new run.
- Reset mid-run: assert resetn=0 at cycle 40 → acc_we low immediately, no done; next start produces a full clean run.
